// File: rtl/meep_axi_pkg.sv
// Shared AXI4 definitions for the MEEP memory-path gate: default widths,
// burst/response encodings and the outstanding-counter width helper.
package meep_axi_pkg;

    localparam int DEF_ID_W   = 6;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 256;
    localparam int DEF_USER_W = 11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Wide enough to hold every value from 0 up to and including max.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/meep_mem_axi_gate_if.sv
// AXI4 bundle (all five channels, full payload) with master/slave views.
interface meep_mem_axi_gate_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 256,
    parameter int USER_W = 11
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic [USER_W-1:0]   awuser;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic [USER_W-1:0]   wuser;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic [USER_W-1:0]   buser;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic [USER_W-1:0]   aruser;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [USER_W-1:0]   ruser;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

endinterface

// File: rtl/meep_axi_txn_counter.sv
// Saturating up/down transaction counter; a simultaneous inc and dec cancel.
module meep_axi_txn_counter #(
    parameter int MAX   = 16,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             zero,
    output logic             underflow
);

    assign full      = (cnt == CNT_W'(MAX));
    assign zero      = (cnt == '0);
    // A lone decrement with nothing counted is a response without a request.
    assign underflow = dec & ~inc & zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/meep_mem_axi_gate.sv
// AXI4 gate in front of the memory controller: holds traffic until calibration,
// bounds outstanding reads/writes, orders W behind AW and supports draining.
module meep_mem_axi_gate
    import meep_axi_pkg::*;
#(
    parameter int ID_W            = DEF_ID_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int USER_W          = DEF_USER_W,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_calib_complete,
    input  logic                     drain_req,
    output logic                     drain_ack,
    output logic [CNT_W-1:0]         rd_outstanding,
    output logic [CNT_W-1:0]         wr_outstanding,
    output logic                     resp_err,
    meep_mem_axi_gate_if.slave       s_axi,
    meep_mem_axi_gate_if.master      m_axi
);

    logic open_q;
    logic ar_commit;
    logic aw_commit;

    logic             rd_full, rd_zero, rd_underflow;
    logic             wr_full, wr_zero, wr_underflow;
    logic             wpend_zero;
    logic [CNT_W-1:0] wpend_cnt_unused;
    logic             wpend_full_unused;
    logic             wpend_underflow_unused;

    logic ar_allow, aw_allow, w_allow;
    logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

    // A committed valid stays allowed so nothing presented downstream is withdrawn.
    assign ar_allow = open_q & ~rd_full & (~drain_req | ar_commit);
    assign aw_allow = open_q & ~wr_full & (~drain_req | aw_commit);
    assign w_allow  = ~wpend_zero;

    assign m_axi.arvalid = s_axi.arvalid & ar_allow;
    assign s_axi.arready = m_axi.arready & ar_allow;
    assign m_axi.awvalid = s_axi.awvalid & aw_allow;
    assign s_axi.awready = m_axi.awready & aw_allow;
    assign m_axi.wvalid  = s_axi.wvalid & w_allow;
    assign s_axi.wready  = m_axi.wready & w_allow;

    assign ar_hs     = m_axi.arvalid & m_axi.arready;
    assign aw_hs     = m_axi.awvalid & m_axi.awready;
    assign w_last_hs = m_axi.wvalid & m_axi.wready & s_axi.wlast;
    assign r_last_hs = m_axi.rvalid & s_axi.rready & m_axi.rlast;
    assign b_hs      = m_axi.bvalid & s_axi.bready;

    assign m_axi.awid     = ID_W'(s_axi.awid);
    assign m_axi.awaddr   = ADDR_W'(s_axi.awaddr);
    assign m_axi.awlen    = s_axi.awlen;
    assign m_axi.awsize   = s_axi.awsize;
    assign m_axi.awburst  = s_axi.awburst;
    assign m_axi.awlock   = s_axi.awlock;
    assign m_axi.awcache  = s_axi.awcache;
    assign m_axi.awprot   = s_axi.awprot;
    assign m_axi.awqos    = s_axi.awqos;
    assign m_axi.awregion = s_axi.awregion;
    assign m_axi.awuser   = USER_W'(s_axi.awuser);

    assign m_axi.wid      = ID_W'(s_axi.wid);
    assign m_axi.wdata    = DATA_W'(s_axi.wdata);
    assign m_axi.wstrb    = (DATA_W/8)'(s_axi.wstrb);
    assign m_axi.wlast    = s_axi.wlast;
    assign m_axi.wuser    = USER_W'(s_axi.wuser);

    assign m_axi.arid     = ID_W'(s_axi.arid);
    assign m_axi.araddr   = ADDR_W'(s_axi.araddr);
    assign m_axi.arlen    = s_axi.arlen;
    assign m_axi.arsize   = s_axi.arsize;
    assign m_axi.arburst  = s_axi.arburst;
    assign m_axi.arlock   = s_axi.arlock;
    assign m_axi.arcache  = s_axi.arcache;
    assign m_axi.arprot   = s_axi.arprot;
    assign m_axi.arqos    = s_axi.arqos;
    assign m_axi.arregion = s_axi.arregion;
    assign m_axi.aruser   = USER_W'(s_axi.aruser);

    assign s_axi.rid      = ID_W'(m_axi.rid);
    assign s_axi.rdata    = DATA_W'(m_axi.rdata);
    assign s_axi.rresp    = m_axi.rresp;
    assign s_axi.rlast    = m_axi.rlast;
    assign s_axi.ruser    = USER_W'(m_axi.ruser);
    assign s_axi.rvalid   = m_axi.rvalid;
    assign m_axi.rready   = s_axi.rready;

    assign s_axi.bid      = ID_W'(m_axi.bid);
    assign s_axi.bresp    = m_axi.bresp;
    assign s_axi.buser    = USER_W'(m_axi.buser);
    assign s_axi.bvalid   = m_axi.bvalid;
    assign m_axi.bready   = s_axi.bready;

    meep_axi_txn_counter #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_rd_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (ar_hs),
        .dec       (r_last_hs),
        .cnt       (rd_outstanding),
        .full      (rd_full),
        .zero      (rd_zero),
        .underflow (rd_underflow)
    );

    meep_axi_txn_counter #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_wr_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (aw_hs),
        .dec       (b_hs),
        .cnt       (wr_outstanding),
        .full      (wr_full),
        .zero      (wr_zero),
        .underflow (wr_underflow)
    );

    meep_axi_txn_counter #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_wpend_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (aw_hs),
        .dec       (w_last_hs),
        .cnt       (wpend_cnt_unused),
        .full      (wpend_full_unused),
        .zero      (wpend_zero),
        .underflow (wpend_underflow_unused)
    );

    // open_q latches calibration once; a later calib drop does not close the gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q    <= 1'b0;
            ar_commit <= 1'b0;
            aw_commit <= 1'b0;
            drain_ack <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            open_q <= open_q | mem_calib_complete;

            if (ar_hs) begin
                ar_commit <= 1'b0;
            end else if (m_axi.arvalid) begin
                ar_commit <= 1'b1;
            end

            if (aw_hs) begin
                aw_commit <= 1'b0;
            end else if (m_axi.awvalid) begin
                aw_commit <= 1'b1;
            end

            drain_ack <= drain_req & rd_zero & wr_zero & wpend_zero
                         & ~ar_commit & ~aw_commit;
            resp_err  <= resp_err | rd_underflow | wr_underflow;
        end
    end

endmodule

// File: tb/tb_meep_mem_axi_gate.sv
// Directed bench for meep_mem_axi_gate with MAX_OUTSTANDING=4.
module tb_meep_mem_axi_gate;

    localparam int MAXO  = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             mem_calib_complete;
    logic             drain_req;
    logic             drain_ack;
    logic [CNT_W-1:0] rd_outstanding;
    logic [CNT_W-1:0] wr_outstanding;
    logic             resp_err;

    int total = 0;
    int bad   = 0;

    meep_mem_axi_gate_if s_if ();
    meep_mem_axi_gate_if m_if ();

    meep_mem_axi_gate #(.MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_calib_complete (mem_calib_complete),
        .drain_req          (drain_req),
        .drain_ack          (drain_ack),
        .rd_outstanding     (rd_outstanding),
        .wr_outstanding     (wr_outstanding),
        .resp_err           (resp_err),
        .s_axi              (s_if.slave),
        .m_axi              (m_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = 3'd5;
        s_if.awburst = 2'b01; s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0;
        s_if.awqos = '0; s_if.awregion = '0; s_if.awuser = '0; s_if.awvalid = 1'b0;
        s_if.wid = '0; s_if.wdata = '0; s_if.wstrb = '1; s_if.wlast = 1'b0;
        s_if.wuser = '0; s_if.wvalid = 1'b0; s_if.bready = 1'b1;
        s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = 3'd5;
        s_if.arburst = 2'b01; s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0;
        s_if.arqos = '0; s_if.arregion = '0; s_if.aruser = '0; s_if.arvalid = 1'b0;
        s_if.rready = 1'b1;
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
        m_if.bid = '0; m_if.bresp = '0; m_if.buser = '0; m_if.bvalid = 1'b0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
        m_if.ruser = '0; m_if.rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_calib_complete = 1'b0;
        drain_req = 1'b1;
        applyStimulus();
        s_if.arvalid = 1'b1;
        s_if.wvalid  = 1'b1;
        repeat (2) stepCycle();
        checkOutput("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
        checkOutput("rst_s_arready", 64'(s_if.arready), 64'd0);
        checkOutput("rst_s_wready", 64'(s_if.wready), 64'd0);
        checkOutput("rst_drain_ack", 64'(drain_ack), 64'd0);
        checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
        checkOutput("rst_rd_out", 64'(rd_outstanding), 64'd0);
        s_if.wvalid = 1'b0;
        drain_req = 1'b0;
        rst = 1'b0;

        // Calibration held low: AR must stay blocked.
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput("calib_low_arvalid", 64'(m_if.arvalid), 64'd0);
        end
        mem_calib_complete = 1'b1;
        s_if.araddr = 64'h0000_1234_5678_9ac0;
        #1;
        checkOutput("calib_same_cycle", 64'(m_if.arvalid), 64'd0);
        stepCycle();
        checkOutput("calib_next_arvalid", 64'(m_if.arvalid), 64'd1);
        checkOutput("calib_next_arready", 64'(s_if.arready), 64'd1);
        checkOutput("araddr_pass", m_if.araddr, 64'h0000_1234_5678_9ac0);

        // Four ARs fill the limit, the fifth stalls.
        stepCycle();
        checkOutput("rd_cnt_1", 64'(rd_outstanding), 64'd1);
        repeat (3) stepCycle();
        checkOutput("rd_cnt_full", 64'(rd_outstanding), 64'd4);
        checkOutput("full_arvalid", 64'(m_if.arvalid), 64'd0);
        checkOutput("full_arready", 64'(s_if.arready), 64'd0);
        stepCycle();
        checkOutput("full_hold", 64'(rd_outstanding), 64'd4);
        checkOutput("full_hold_arvalid", 64'(m_if.arvalid), 64'd0);

        m_if.rvalid = 1'b1;
        m_if.rlast  = 1'b1;
        m_if.rdata  = 256'h0000_0000_0000_0000_dead_beef_cafe_f00d;
        #1;
        checkOutput("r_pass_valid", 64'(s_if.rvalid), 64'd1);
        checkOutput("r_pass_data", s_if.rdata[63:0], 64'hdead_beef_cafe_f00d);
        checkOutput("r_pass_ready", 64'(m_if.rready), 64'd1);
        checkOutput("rlast_cycle_arvalid", 64'(m_if.arvalid), 64'd0);
        stepCycle();
        m_if.rvalid = 1'b0;
        #1;
        checkOutput("after_rlast_cnt", 64'(rd_outstanding), 64'd3);
        checkOutput("after_rlast_arvalid", 64'(m_if.arvalid), 64'd1);
        stepCycle();
        checkOutput("fifth_accepted", 64'(rd_outstanding), 64'd4);
        s_if.arvalid = 1'b0;

        // Bring rd_cnt to 2, then check non-last beats and a simultaneous inc/dec.
        m_if.rvalid = 1'b1;
        repeat (2) stepCycle();
        m_if.rvalid = 1'b0;
        checkOutput("rd_cnt_2", 64'(rd_outstanding), 64'd2);
        m_if.rvalid = 1'b1;
        m_if.rlast  = 1'b0;
        stepCycle();
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b1;
        checkOutput("nonlast_no_dec", 64'(rd_outstanding), 64'd2);
        s_if.arvalid = 1'b1;
        m_if.rvalid  = 1'b1;
        #1;
        checkOutput("same_cycle_arvalid", 64'(m_if.arvalid), 64'd1);
        stepCycle();
        s_if.arvalid = 1'b0;
        m_if.rvalid  = 1'b0;
        checkOutput("same_cycle_cnt", 64'(rd_outstanding), 64'd2);

        // Drain with a committed AR pending downstream.
        m_if.rvalid = 1'b1;
        repeat (2) stepCycle();
        m_if.rvalid = 1'b0;
        checkOutput("rd_cnt_0", 64'(rd_outstanding), 64'd0);
        m_if.arready = 1'b0;
        s_if.arvalid = 1'b1;
        #1;
        checkOutput("stall_arvalid", 64'(m_if.arvalid), 64'd1);
        checkOutput("stall_arready", 64'(s_if.arready), 64'd0);
        stepCycle();
        drain_req = 1'b1;
        #1;
        checkOutput("drain_commit_held", 64'(m_if.arvalid), 64'd1);
        stepCycle();
        checkOutput("drain_commit_held2", 64'(m_if.arvalid), 64'd1);
        checkOutput("drain_ack_busy", 64'(drain_ack), 64'd0);
        m_if.arready = 1'b1;
        #1;
        checkOutput("drain_hs_ready", 64'(s_if.arready), 64'd1);
        stepCycle();
        checkOutput("drain_hs_cnt", 64'(rd_outstanding), 64'd1);
        checkOutput("drain_blocks_ar", 64'(m_if.arvalid), 64'd0);
        checkOutput("drain_blocks_ready", 64'(s_if.arready), 64'd0);
        s_if.arvalid = 1'b0;
        m_if.rvalid  = 1'b1;
        stepCycle();
        m_if.rvalid = 1'b0;
        checkOutput("drain_last_r_cnt", 64'(rd_outstanding), 64'd0);
        checkOutput("drain_ack_not_yet", 64'(drain_ack), 64'd0);
        stepCycle();
        checkOutput("drain_ack_up", 64'(drain_ack), 64'd1);
        drain_req = 1'b0;
        stepCycle();
        checkOutput("drain_ack_down", 64'(drain_ack), 64'd0);

        // AW then W: W held one cycle behind its AW.
        s_if.awvalid = 1'b1;
        s_if.awaddr  = 64'h0000_0000_8000_0040;
        s_if.wvalid  = 1'b1;
        s_if.wlast   = 1'b0;
        #1;
        checkOutput("aw_valid", 64'(m_if.awvalid), 64'd1);
        checkOutput("aw_ready", 64'(s_if.awready), 64'd1);
        checkOutput("aw_addr_pass", m_if.awaddr, 64'h0000_0000_8000_0040);
        checkOutput("w_blocked_wready", 64'(s_if.wready), 64'd0);
        checkOutput("w_blocked_wvalid", 64'(m_if.wvalid), 64'd0);
        stepCycle();
        s_if.awvalid = 1'b0;
        #1;
        checkOutput("wr_cnt_1", 64'(wr_outstanding), 64'd1);
        checkOutput("w_flow_wready", 64'(s_if.wready), 64'd1);
        checkOutput("w_flow_wvalid", 64'(m_if.wvalid), 64'd1);
        stepCycle();
        s_if.wlast = 1'b1;
        stepCycle();
        s_if.wvalid = 1'b0;
        s_if.wlast  = 1'b0;
        checkOutput("wpend_empty_wready", 64'(s_if.wready), 64'd0);
        checkOutput("wr_cnt_still_1", 64'(wr_outstanding), 64'd1);

        // B responses: one matched, one with nothing outstanding.
        m_if.bvalid = 1'b1;
        #1;
        checkOutput("b_pass_valid", 64'(s_if.bvalid), 64'd1);
        checkOutput("b_pass_ready", 64'(m_if.bready), 64'd1);
        stepCycle();
        checkOutput("wr_cnt_0", 64'(wr_outstanding), 64'd0);
        checkOutput("resp_err_clean", 64'(resp_err), 64'd0);
        stepCycle();
        m_if.bvalid = 1'b0;
        checkOutput("underflow_cnt", 64'(wr_outstanding), 64'd0);
        checkOutput("underflow_err", 64'(resp_err), 64'd1);
        repeat (3) stepCycle();
        checkOutput("resp_err_sticky", 64'(resp_err), 64'd1);

        // Reset clears the sticky flag and closes the gate again.
        rst = 1'b1;
        s_if.arvalid = 1'b1;
        #1;
        checkOutput("rst2_resp_err", 64'(resp_err), 64'd0);
        checkOutput("rst2_arvalid", 64'(m_if.arvalid), 64'd0);
        checkOutput("rst2_drain_ack", 64'(drain_ack), 64'd0);
        s_if.arvalid = 1'b0;
        stepCycle();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
